// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the ROM read port plus the core instruction handshake.
// Latency: none, this is wiring only.
// Backpressure: instr_ready from the core. The ROM side has no stall.
//
// Signals:
//   rom_addr       fetch -> ROM   word address, registered inside the fetch unit
//   rom_q          ROM -> fetch   data for the address presented one cycle earlier
//   redirect_valid core -> fetch  PC change request (flushes the prefetch buffer)
//   redirect_pc    core -> fetch  redirect target
//   instr_valid    fetch -> core  head of the prefetch buffer is valid
//   instr_ready    core -> fetch  core takes the head this cycle
//   instr_data     fetch -> core  head instruction word
//   instr_pc       fetch -> core  word address of the head instruction
// master = fetch unit side, slave = ROM/core side.
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_q;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output rom_addr,
        input  rom_q,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  rom_addr,
        output rom_q,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives ROM word addresses and buffers {pc, data} in a small prefetch FIFO.
// Latency: 2 cycles from address issue to instr_valid. Sustains 1 instr/cycle with instr_ready held high.
// Backpressure: stops issuing addresses when buffered + in-flight entries would exceed FIFO_DEPTH.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   bus (master)   ROM read port, redirect request and core instruction handshake (see fetch_unit_if)
//   halted         every fetch up to LAST_PC has been consumed and nothing is pending
//   perf_fetched   (FETCH_PERF_EN only) saturating count of instructions handed to the core
//   perf_flushes   (FETCH_PERF_EN only) saturating count of redirect cycles
// Optional feature macro: FETCH_PERF_EN adds the two performance counters.
// ADDR_WIDTH/DATA_WIDTH must match the parameters of the connected interface instance.
// FIFO_DEPTH legal range is 2..16.
module fetch_unit #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int LAST_PC    = 2**ADDR_WIDTH - 1,
    parameter int START_PC   = 0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      bus,
    output logic              halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [15:0]       perf_flushes
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(LAST_PC);
    localparam logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(START_PC);
    localparam logic [CW:0]           DEPTH_OCC  = (CW+1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]         LAST_IDX   = PW'(FIFO_DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  done_q;
    logic                  inflight_q;
    logic [ADDR_WIDTH-1:0] inflight_pc_q;

    logic [CW-1:0]         count_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         wr_ptr_q;

    logic [ADDR_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic          head_vld;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ_next;

    assign head_vld = (count_q != '0);

    // A redirect flushes the head, so a same-cycle accept is not a pop.
    assign pop  = head_vld & bus.instr_ready & ~bus.redirect_valid;

    // The ROM answer for last cycle's address lands now; a redirect discards it.
    assign push = inflight_q & ~bus.redirect_valid;

    // Slots that will be taken after this edge if nothing new is issued.
    // pop implies count_q >= 1, so this never underflows.
    assign occ_next = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    assign issue = ~done_q & ~bus.redirect_valid & (occ_next < DEPTH_OCC);

    // ------------------------------------------------------------------
    // PC / request tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= START_ADDR;
            done_q        <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= START_ADDR;
        end else if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_pc;
            // A target beyond the last fetchable word leaves nothing to do.
            done_q     <= (bus.redirect_pc > LAST_ADDR);
            inflight_q <= 1'b0;
        end else if (issue) begin
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
            // Park on LAST_PC instead of incrementing so pc_q never wraps.
            if (pc_q == LAST_ADDR) begin
                done_q <= 1'b1;
            end else begin
                pc_q <= pc_q + ADDR_WIDTH'(1);
            end
        end else begin
            inflight_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO control
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        // Explicit wrap so non-power-of-two depths work.
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst || bus.redirect_valid) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset: entries are only observed while counted valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]   <= inflight_pc_q;
            mem_data[wr_ptr_q] <= bus.rom_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rom_addr    = pc_q;
    assign bus.instr_valid = head_vld;
    assign bus.instr_data  = mem_data[rd_ptr_q];
    assign bus.instr_pc    = mem_pc[rd_ptr_q];

    assign halted = done_q & ~inflight_q & (count_q == '0);

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (saturating)
    // ------------------------------------------------------------------
    logic [31:0] fetched_q;
    logic [15:0] flushes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            flushes_q <= '0;
        end else begin
            if (pop && (fetched_q != '1)) begin
                fetched_q <= fetched_q + 32'd1;
            end
            if (bus.redirect_valid && (flushes_q != '1)) begin
                flushes_q <= flushes_q + 16'd1;
            end
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushes = flushes_q;
`endif

endmodule
